// File: rtl/scram_axil_bridge.sv
// scram_axil_bridge
//   AXI4-lite slave that turns each single-beat read or write into one native
//   access on a scratchpad RAM port. One transaction is in flight at a time;
//   reads and writes are picked round-robin when both are waiting.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*        AXI4-lite write address / data / response
//   s_ar*, s_r*              AXI4-lite read address / data
//   mem_en, mem_wr           native access request and direction (registered)
//   mem_addr, mem_wdata,
//   mem_strb                 native word address, write data, byte enables
//   mem_rdata, mem_ready     native read data and access-complete indication
module scram_axil_bridge #(
  parameter int AXI_ADDRW = 16,
  parameter int ADDRW     = 4,
  parameter int DATAW     = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [AXI_ADDRW-1:0] s_awaddr,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic [DATAW-1:0]     s_wdata,
  input  logic [DATAW/8-1:0]   s_wstrb,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  output logic [1:0]           s_bresp,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  input  logic [AXI_ADDRW-1:0] s_araddr,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [DATAW-1:0]     s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDRW-1:0]     mem_addr,
  output logic [DATAW-1:0]     mem_wdata,
  output logic [DATAW/8-1:0]   mem_strb,
  input  logic [DATAW-1:0]     mem_rdata,
  input  logic                 mem_ready
);

  localparam int OFF = $clog2(DATAW/8);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MWR,
    S_MRD,
    S_BRESP,
    S_RRESP
  } state_t;

  state_t               r_state;
  logic                 r_last_wr;
  logic                 r_mem_en;
  logic                 r_mem_wr;
  logic [ADDRW-1:0]     r_mem_addr;
  logic [DATAW-1:0]     r_mem_wdata;
  logic [DATAW/8-1:0]   r_mem_strb;
  logic                 r_bvalid;
  logic [1:0]           r_bresp;
  logic                 r_rvalid;
  logic [DATAW-1:0]     r_rdata;
  logic [1:0]           r_rresp;

  logic w_idle;
  logic w_wr_elig;
  logic w_rd_elig;
  logic w_sel_wr;
  logic w_sel_rd;
  logic w_aw_oor;
  logic w_ar_oor;

  // A write needs both AW and W present; it is never half-accepted.
  // When both directions are eligible, the one not served last wins.
  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_elig = s_awvalid && s_wvalid;
  assign w_rd_elig = s_arvalid;
  assign w_sel_wr  = w_wr_elig && (!w_rd_elig || !r_last_wr);
  assign w_sel_rd  = w_rd_elig && (!w_wr_elig ||  r_last_wr);

  // Any address bit above the RAM's word range marks the access as out of range.
  assign w_aw_oor = |(s_awaddr >> (ADDRW + OFF));
  assign w_ar_oor = |(s_araddr >> (ADDRW + OFF));

  assign s_awready = w_idle && w_sel_wr;
  assign s_wready  = w_idle && w_sel_wr;
  assign s_arready = w_idle && w_sel_rd;

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_strb  = r_mem_strb;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

  // Transaction FSM. mem_en is dropped on the same edge that sees mem_ready,
  // so every access is followed by at least one idle cycle on the memory port.
  // Out-of-range requests skip the memory and go straight to an error response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_last_wr   <= 1'b1;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_strb  <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_wr) begin
            r_last_wr   <= 1'b1;
            r_mem_addr  <= s_awaddr[ADDRW+OFF-1:OFF];
            r_mem_wdata <= s_wdata;
            r_mem_strb  <= s_wstrb;
            if (w_aw_oor) begin
              r_bresp  <= RESP_SLVERR;
              r_bvalid <= 1'b1;
              r_state  <= S_BRESP;
            end else begin
              r_mem_en <= 1'b1;
              r_mem_wr <= 1'b1;
              r_state  <= S_MWR;
            end
          end else if (w_sel_rd) begin
            r_last_wr  <= 1'b0;
            r_mem_addr <= s_araddr[ADDRW+OFF-1:OFF];
            if (w_ar_oor) begin
              r_rdata  <= '0;
              r_rresp  <= RESP_SLVERR;
              r_rvalid <= 1'b1;
              r_state  <= S_RRESP;
            end else begin
              r_mem_en <= 1'b1;
              r_mem_wr <= 1'b0;
              r_state  <= S_MRD;
            end
          end
        end
        S_MWR: begin
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_bvalid <= 1'b1;
            r_state  <= S_BRESP;
          end
        end
        S_MRD: begin
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            r_rdata  <= mem_rdata;
            r_rresp  <= RESP_OKAY;
            r_rvalid <= 1'b1;
            r_state  <= S_RRESP;
          end
        end
        S_BRESP: begin
          if (s_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RRESP: begin
          if (s_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
